// File: rtl/featuremap_relu_maxpool2x2_pkg.sv
// -----------------------------------------------------------------------------
// featuremap_relu_maxpool2x2_pkg
// Shared FP32 helpers for the featuremap post-processing stages.
//   FP_WIDTH     : word width of an IEEE-754 single-precision value
//   FP_SIGN_BIT  : bit index of the sign
//   FP_POS_ZERO  : +0.0 bit pattern
//   relu()       : sign-clear-to-zero; any word with the sign set
//                  (-0.0, -Inf, negative NaN, negative finite) becomes +0.0
// -----------------------------------------------------------------------------
package featuremap_relu_maxpool2x2_pkg;

    localparam int FP_WIDTH    = 32;
    localparam int FP_SIGN_BIT = FP_WIDTH - 1;

    localparam logic [FP_WIDTH-1:0] FP_POS_ZERO = 32'h0000_0000;

    // Positive words (including +Inf and positive NaN) pass unchanged.
    function automatic logic [FP_WIDTH-1:0] relu(input logic [FP_WIDTH-1:0] x);
        logic [FP_WIDTH-1:0] r;
        if (x[FP_SIGN_BIT]) begin
            r = FP_POS_ZERO;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/featuremap_relu_maxpool2x2_nonneg_max2.sv
// -----------------------------------------------------------------------------
// fp32_nonneg_max2
// Combinational max of two non-negative FP32 words.
//   a, b    : operands, sign bit assumed clear
//   max_out : the larger operand
// For non-negative IEEE-754 values the bit pattern orders the same way as the
// value, so an unsigned integer compare of the whole word is exact. On a tie
// both operands are bit-identical, so which one is taken does not matter.
// -----------------------------------------------------------------------------
module fp32_nonneg_max2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] max_out
);

    // Select the larger operand by unsigned word compare.
    always_comb begin
        max_out = a;
        if (b > a) begin
            max_out = b;
        end else begin
            max_out = a;
        end
    end

endmodule

// File: rtl/featuremap_relu_maxpool2x2.sv
// -----------------------------------------------------------------------------
// featuremap_relu_maxpool2x2
// ReLU followed by 2x2 / stride-2 max-pooling on a raster-ordered FP32
// feature-map stream. Produces a WIDTH/2 x HEIGHT/2 map in raster order.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   valid_in   : data_in carries one pixel this cycle (any duty cycle)
//   data_in    : FP32 pixel, row-major, column 0 first
//   valid_out  : one-cycle strobe, data_out holds a pooled pixel
//   data_out   : pooled FP32 pixel (always >= +0.0), held between strobes
//   frame_done : one-cycle strobe with the last pooled pixel of a frame
// Even rows: the horizontal pair max is parked in the line buffer.
// Odd rows: the horizontal pair max is combined with the parked value and
// emitted. Reads and writes of the line buffer never share a row.
// -----------------------------------------------------------------------------
module featuremap_relu_maxpool2x2
    import featuremap_relu_maxpool2x2_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 112,
    parameter int HEIGHT     = 112
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done
);

    localparam int COL_W    = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W    = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int LB_DEPTH = WIDTH / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [COL_W-1:0]      col_r;
    logic [ROW_W-1:0]      row_r;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [DATA_WIDTH-1:0] linebuf_r [LB_DEPTH];

    logic [DATA_WIDTH-1:0] relu_s;
    logic [DATA_WIDTH-1:0] pair_max_s;
    logic [DATA_WIDTH-1:0] win_max_s;
    logic [LB_AW-1:0]      lb_idx_s;
    logic                  col_last_s;
    logic                  row_last_s;
    logic                  lb_wr_s;
    logic                  out_evt_s;

    assign relu_s     = relu(data_in);
    assign lb_idx_s   = LB_AW'(col_r >> 1);
    assign col_last_s = (col_r == COL_W'(WIDTH - 1));
    assign row_last_s = (row_r == ROW_W'(HEIGHT - 1));
    assign lb_wr_s    = valid_in & ~row_r[0] & col_r[0];
    assign out_evt_s  = valid_in &  row_r[0] & col_r[0];

    // Horizontal max of the held even-column pixel and the current pixel.
    fp32_nonneg_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_pair_max (
        .a       (hold_r),
        .b       (relu_s),
        .max_out (pair_max_s)
    );

    // Vertical max of this row's pair and the pair parked from the row above.
    fp32_nonneg_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_win_max (
        .a       (pair_max_s),
        .b       (linebuf_r[lb_idx_s]),
        .max_out (win_max_s)
    );

    // Raster position counters, advanced only by accepted pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r <= COL_W'(0);
            row_r <= ROW_W'(0);
        end else if (valid_in) begin
            if (col_last_s) begin
                col_r <= COL_W'(0);
                row_r <= row_last_s ? ROW_W'(0) : (row_r + ROW_W'(1));
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Hold register captures the ReLU'd even-column pixel of each pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r <= {DATA_WIDTH{1'b0}};
        end else if (valid_in && !col_r[0]) begin
            hold_r <= relu_s;
        end
    end

    // Line buffer: no reset, every entry is written on an even row before use.
    always_ff @(posedge clk) begin
        if (!rst && lb_wr_s) begin
            linebuf_r[lb_idx_s] <= pair_max_s;
        end
    end

    // Output register and strobes, one cycle after the window's last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= {DATA_WIDTH{1'b0}};
        end else begin
            valid_out  <= out_evt_s;
            frame_done <= out_evt_s & row_last_s & col_last_s;
            if (out_evt_s) begin
                data_out <= win_max_s;
            end
        end
    end

endmodule

// File: tb/tb_featuremap_relu_maxpool2x2.sv
module tb_featuremap_relu_maxpool2x2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // a: 4x4, b: 4x2, c: 112x112
    logic vi_a, vo_a, fd_a;
    logic [31:0] di_a, do_a;
    logic vi_b, vo_b, fd_b;
    logic [31:0] di_b, do_b;
    logic vi_c, vo_c, fd_c;
    logic [31:0] di_c, do_c;

    featuremap_relu_maxpool2x2 #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) u_dut_a (
        .clk(clk), .rst(rst), .valid_in(vi_a), .data_in(di_a),
        .valid_out(vo_a), .data_out(do_a), .frame_done(fd_a));
    featuremap_relu_maxpool2x2 #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(2)) u_dut_b (
        .clk(clk), .rst(rst), .valid_in(vi_b), .data_in(di_b),
        .valid_out(vo_b), .data_out(do_b), .frame_done(fd_b));
    featuremap_relu_maxpool2x2 #(.DATA_WIDTH(32), .WIDTH(112), .HEIGHT(112)) u_dut_c (
        .clk(clk), .rst(rst), .valid_in(vi_c), .data_in(di_c),
        .valid_out(vo_c), .data_out(do_c), .frame_done(fd_c));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // float(n) for n = 0..16
    logic [31:0] flt [17];
    logic [31:0] frm [16];

    // ---------------- monitors (sample on the falling edge) ----------------
    logic [31:0] oa_q[$];
    int          ta_q[$];
    logic        fa_q[$];
    int          pix_a  = 0;
    int          prev_a = -1;
    int          fdc_a  = 0;
    int          stray_a = 0;

    always @(negedge clk) begin
        if (vo_a === 1'b1) begin
            oa_q.push_back(do_a);
            ta_q.push_back(prev_a);
            fa_q.push_back(fd_a);
        end
        if (fd_a === 1'b1) fdc_a++;
        if (fd_a === 1'b1 && vo_a !== 1'b1) stray_a++;
        prev_a = (vi_a === 1'b1) ? pix_a : -1;
    end

    logic [31:0] ob_q[$];
    logic        fb_q[$];
    int          fdc_b = 0;

    always @(negedge clk) begin
        if (vo_b === 1'b1) begin
            ob_q.push_back(do_b);
            fb_q.push_back(fd_b);
        end
        if (fd_b === 1'b1) fdc_b++;
    end

    logic [31:0] oc_q[$];
    int          fdc_c = 0;

    always @(negedge clk) begin
        if (vo_c === 1'b1) oc_q.push_back(do_c);
        if (fd_c === 1'b1) fdc_c++;
    end

    // ---------------- drivers ----------------
    task automatic drive_a(input int idx, input logic [31:0] d);
        @(posedge clk); #1;
        vi_a = 1'b1; di_a = d; pix_a = idx;
    endtask

    task automatic idle_all(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            vi_a = 1'b0; vi_b = 1'b0; vi_c = 1'b0;
        end
    endtask

    task automatic send_frame_a();
        for (int p = 0; p < 16; p++) drive_a(p, frm[p]);
    endtask

    // Pop four outputs of a 4x4 frame; check value, source pixel (latency) and frame_done.
    task automatic check_out_a(input string name, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] exp_v [4];
        int          exp_t [4];
        logic [31:0] v;
        int          t;
        logic        f;
        exp_v = '{e0, e1, e2, e3};
        exp_t = '{5, 7, 13, 15};
        check_eq({name, "_avail"}, 32'(oa_q.size() >= 4), 32'd1);
        if (oa_q.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                v = oa_q.pop_front();
                t = ta_q.pop_front();
                f = fa_q.pop_front();
                check_eq($sformatf("%s_val%0d", name, k), v, exp_v[k]);
                check_eq($sformatf("%s_src%0d", name, k), 32'(t), 32'(exp_t[k]));
                check_eq($sformatf("%s_fd%0d", name, k), {31'd0, f}, {31'd0, (k == 3)});
            end
        end
    endtask

    // ---------------- big-frame golden model ----------------
    logic [31:0] big [112*112];
    logic [31:0] exp_c [$];

    function automatic logic [31:0] relu_m(input logic [31:0] x);
        return x[31] ? 32'h0000_0000 : x;
    endfunction

    function automatic logic [31:0] max_m(input logic [31:0] x, input logic [31:0] y);
        return (x > y) ? x : y;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int snap;
        logic [31:0] m;
        flt = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000,
                32'h4120_0000, 32'h4130_0000, 32'h4140_0000, 32'h4150_0000, 32'h4160_0000,
                32'h4170_0000, 32'h4180_0000};

        rst = 1'b1;
        vi_a = 1'b0; vi_b = 1'b0; vi_c = 1'b0;
        di_a = 32'd0; di_b = 32'd0; di_c = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_vo_a", {31'd0, vo_a}, 32'd0);
        check_eq("rst_fd_a", {31'd0, fd_a}, 32'd0);
        check_eq("rst_do_a", do_a, 32'd0);
        check_eq("rst_vo_c", {31'd0, vo_c}, 32'd0);
        check_eq("rst_do_c", do_c, 32'd0);

        // Test 1: ascending 4x4 frame
        for (int p = 0; p < 16; p++) frm[p] = flt[p+1];
        snap = fdc_a;
        send_frame_a();
        idle_all(3);
        check_out_a("t1", flt[6], flt[8], flt[14], flt[16]);
        check_eq("t1_left", 32'(oa_q.size()), 32'd0);
        check_eq("t1_fdcnt", 32'(fdc_a - snap), 32'd1);

        // Test 2: 4x2, all negative plus one -0.0
        for (int p = 0; p < 8; p++) begin
            @(posedge clk); #1;
            vi_b = 1'b1;
            di_b = (p == 5) ? 32'h8000_0000 : 32'hBF80_0000;
        end
        idle_all(3);
        check_eq("t2_cnt", 32'(ob_q.size()), 32'd2);
        check_eq("t2_fdcnt", 32'(fdc_b), 32'd1);
        if (ob_q.size() >= 2) begin
            check_eq("t2_val0", ob_q[0], 32'h0000_0000);
            check_eq("t2_val1", ob_q[1], 32'h0000_0000);
            check_eq("t2_fd0", {31'd0, fb_q[0]}, 32'd0);
            check_eq("t2_fd1", {31'd0, fb_q[1]}, 32'd1);
        end

        // Test 4: two 4x4 frames back-to-back
        snap = fdc_a;
        for (int p = 0; p < 16; p++) drive_a(p, flt[p+1]);
        for (int p = 0; p < 16; p++) drive_a(p, flt[16-p]);
        idle_all(3);
        check_eq("t4_cnt", 32'(oa_q.size()), 32'd8);
        check_out_a("t4a", flt[6], flt[8], flt[14], flt[16]);
        check_out_a("t4b", flt[16], flt[14], flt[8], flt[6]);
        check_eq("t4_fdcnt", 32'(fdc_a - snap), 32'd2);

        // Test 5: reset after 6 pixels, then a full frame
        for (int p = 0; p < 6; p++) drive_a(p, flt[9]);
        @(posedge clk); #1;
        vi_a = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        oa_q.delete(); ta_q.delete(); fa_q.delete();
        snap = fdc_a;
        @(negedge clk);
        check_eq("t5_rst_do", do_a, 32'd0);
        check_eq("t5_rst_vo", {31'd0, vo_a}, 32'd0);
        for (int p = 0; p < 16; p++) frm[p] = flt[p+1];
        send_frame_a();
        idle_all(3);
        check_out_a("t5", flt[6], flt[8], flt[14], flt[16]);
        check_eq("t5_left", 32'(oa_q.size()), 32'd0);
        check_eq("t5_fdcnt", 32'(fdc_a - snap), 32'd1);

        // Test 6: special values (+Inf, tie, +NaN, negatives vs denormal)
        frm = '{32'h7F80_0000, 32'h4040_0000, 32'h4000_0000, 32'h4000_0000,
                32'h3F80_0000, 32'hC000_0000, 32'h4000_0000, 32'h4000_0000,
                32'h7FC0_0000, 32'h3F80_0000, 32'hFFC0_0000, 32'hFF80_0000,
                32'h3F80_0000, 32'h3F80_0000, 32'h8000_0000, 32'h0000_0001};
        snap = fdc_a;
        send_frame_a();
        idle_all(3);
        check_out_a("t6", 32'h7F80_0000, 32'h4000_0000, 32'h7FC0_0000, 32'h0000_0001);
        check_eq("t6_fdcnt", 32'(fdc_a - snap), 32'd1);
        check_eq("stray_fd_a", 32'(stray_a), 32'd0);

        // Test 3: 112x112 random frame at ~40% valid duty
        for (int p = 0; p < 112*112; p++) big[p] = $urandom;
        for (int r = 0; r < 56; r++) begin
            for (int c = 0; c < 56; c++) begin
                m = max_m(max_m(relu_m(big[(2*r)*112 + 2*c]), relu_m(big[(2*r)*112 + 2*c + 1])),
                          max_m(relu_m(big[(2*r+1)*112 + 2*c]), relu_m(big[(2*r+1)*112 + 2*c + 1])));
                exp_c.push_back(m);
            end
        end
        for (int p = 0; p < 112*112; p++) begin
            while ($urandom_range(99) >= 40) begin
                @(posedge clk); #1;
                vi_c = 1'b0;
            end
            @(posedge clk); #1;
            vi_c = 1'b1; di_c = big[p];
        end
        idle_all(4);
        check_eq("t3_cnt", 32'(oc_q.size()), 32'd3136);
        check_eq("t3_fdcnt", 32'(fdc_c), 32'd1);
        for (int k = 0; k < 3136 && k < oc_q.size(); k++) begin
            check_eq($sformatf("t3_val%0d", k), oc_q[k], exp_c[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
